// File: rtl/local_network_interface.sv
// Tile-side network interface: packetizes PE requests into credit-controlled flits and buffers ejected flits in an RX FIFO.
// Define NI_STATS_EN to add the tx_pkt_cnt_o / rx_flit_cnt_o statistics counters.
module local_network_interface #(
    parameter int BUF_DEPTH = 8,
    parameter int RX_DEPTH  = 8,
    parameter int PKT_LEN   = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef NI_STATS_EN
    output logic [15:0] tx_pkt_cnt_o,
    output logic [15:0] rx_flit_cnt_o,
`endif
    input  logic        tx_start_i,
    input  logic [15:0] tx_dest_i,
    input  logic [15:0] tx_payload_i,
    input  logic        tx_payload_valid_i,
    output logic        tx_payload_ready_o,
    output logic        tx_busy_o,
    output logic [15:0] ni_data_o,
    output logic        ni_valid_o,
    input  logic        ni_credit_i,
    input  logic [15:0] ni_data_i,
    input  logic        ni_valid_i,
    output logic        ni_credit_o,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_read_i,
    output logic        rx_overflow_o
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = $clog2(RX_DEPTH + 1);
    localparam logic [3:0]    CRED_MAX = 4'(BUF_DEPTH);
    localparam logic [3:0]    LAST_PAY = 4'(PKT_LEN - 2);
    localparam logic [PW-1:0] PTR_LAST = PW'(RX_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

    state_e      state_q;
    logic [3:0]  credits_q, credits_d;
    logic [3:0]  pay_cnt_q;
    logic [15:0] dest_q;
    logic [15:0] ni_data_q;
    logic        ni_valid_q;
    logic        has_credit;
    logic        send;

    assign has_credit         = (credits_q != 4'd0);
    assign tx_payload_ready_o = (state_q == BODY) && has_credit && tx_payload_valid_i;
    assign send               = ((state_q == HEAD) && has_credit) || tx_payload_ready_o;
    assign tx_busy_o          = (state_q != IDLE);
    assign ni_data_o          = ni_data_q;
    assign ni_valid_o         = ni_valid_q;

    // A send and a returned credit on the same edge cancel; excess credits saturate rather than wrap.
    always_comb begin
        credits_d = credits_q;
        if (send && !ni_credit_i) begin
            credits_d = credits_q - 4'd1;
        end else if (!send && ni_credit_i && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + 4'd1;
        end
    end

`ifdef NI_STATS_EN
    logic [15:0] tx_pkt_cnt_q;
    assign tx_pkt_cnt_o = tx_pkt_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            credits_q  <= CRED_MAX;
            pay_cnt_q  <= 4'd0;
            dest_q     <= 16'h0000;
            ni_data_q  <= 16'h0000;
            ni_valid_q <= 1'b0;
`ifdef NI_STATS_EN
            tx_pkt_cnt_q <= 16'h0000;
`endif
        end else begin
            ni_valid_q <= send;
            credits_q  <= credits_d;
            case (state_q)
                IDLE: begin
                    if (tx_start_i) begin
                        dest_q    <= tx_dest_i;
                        pay_cnt_q <= 4'd0;
                        state_q   <= HEAD;
                    end
                end
                HEAD: begin
                    if (send) begin
                        ni_data_q <= dest_q;
                        state_q   <= BODY;
                    end
                end
                BODY: begin
                    if (send) begin
                        ni_data_q <= tx_payload_i;
                        pay_cnt_q <= pay_cnt_q + 4'd1;
                        if (pay_cnt_q == LAST_PAY) begin
                            state_q <= IDLE;
`ifdef NI_STATS_EN
                            tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [15:0]   mem_q [RX_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          pop, push, full;

    assign full          = (count_q == CNT_FULL);
    assign pop           = rx_read_i && rx_valid_o;
    assign push          = ni_valid_i && (!full || pop);
    assign rx_valid_o    = (count_q != '0);
    assign rx_data_o     = mem_q[rd_ptr_q];
    assign ni_credit_o   = pop;
    assign rx_overflow_o = overflow_q;

`ifdef NI_STATS_EN
    logic [15:0] rx_flit_cnt_q;
    assign rx_flit_cnt_o = rx_flit_cnt_q;
`endif

    // A pop frees the slot in the same edge, so a full FIFO can accept a write while it is being read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef NI_STATS_EN
            rx_flit_cnt_q <= 16'h0000;
`endif
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= ni_data_i;
                wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (ni_valid_i && full && !pop) begin
                overflow_q <= 1'b1;
            end
`ifdef NI_STATS_EN
            if (ni_valid_i) begin
                rx_flit_cnt_q <= rx_flit_cnt_q + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_local_network_interface.sv
// Scoreboard testbench for local_network_interface: queue-based TX/RX reference model with randomized traffic.
// Build with NI_STATS_EN defined to also check the statistics counters.
module tb_local_network_interface;

    localparam int BUF_DEPTH = 8;
    localparam int RX_DEPTH  = 8;
    localparam int PKT_LEN   = 4;

    logic        clk;
    logic        reset;
    logic        tx_start_i;
    logic [15:0] tx_dest_i;
    logic [15:0] tx_payload_i;
    logic        tx_payload_valid_i;
    logic        tx_payload_ready_o;
    logic        tx_busy_o;
    logic [15:0] ni_data_o;
    logic        ni_valid_o;
    logic        ni_credit_i;
    logic [15:0] ni_data_i;
    logic        ni_valid_i;
    logic        ni_credit_o;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_read_i;
    logic        rx_overflow_o;
`ifdef NI_STATS_EN
    logic [15:0] tx_pkt_cnt_o;
    logic [15:0] rx_flit_cnt_o;
`endif

    local_network_interface #(
        .BUF_DEPTH(BUF_DEPTH),
        .RX_DEPTH (RX_DEPTH),
        .PKT_LEN  (PKT_LEN)
    ) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef NI_STATS_EN
        .tx_pkt_cnt_o      (tx_pkt_cnt_o),
        .rx_flit_cnt_o     (rx_flit_cnt_o),
`endif
        .tx_start_i        (tx_start_i),
        .tx_dest_i         (tx_dest_i),
        .tx_payload_i      (tx_payload_i),
        .tx_payload_valid_i(tx_payload_valid_i),
        .tx_payload_ready_o(tx_payload_ready_o),
        .tx_busy_o         (tx_busy_o),
        .ni_data_o         (ni_data_o),
        .ni_valid_o        (ni_valid_o),
        .ni_credit_i       (ni_credit_i),
        .ni_data_i         (ni_data_i),
        .ni_valid_i        (ni_valid_i),
        .ni_credit_o       (ni_credit_o),
        .rx_data_o         (rx_data_o),
        .rx_valid_o        (rx_valid_o),
        .rx_read_i         (rx_read_i),
        .rx_overflow_o     (rx_overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [15:0] txExp[$];
    logic [15:0] payQ[$];
    logic [15:0] rxModel[$];
    int          flitCyc[$];
    logic [15:0] expFlit;
    int  cyc = 0;
    int  startCyc = 0;
    int  flitsSeen = 0;
    int  creditBal = BUF_DEPTH;
    int  pktPos = 0;
    int  creditsOut = 0;
    int  rxFlitsIn = 0;
    int  pktsIssued = 0;
    bit  ovfExp = 1'b0;
    bit  readySeen = 1'b0;
    bit  payEn = 1'b1;
    bit  gaps = 1'b0;
    bit  creditHold = 1'b0;
    bit  creditRand = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model update after each active edge: TX scoreboard pop, credit balance, RX queue occupancy.
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            cyc++;
            if (ni_valid_o) begin
                flitsSeen++;
                flitCyc.push_back(cyc);
                checkOutput("tx_credit_avail", 32'(creditBal > 0), 1);
                if (txExp.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL tx_extra_flit: got %h, expected no flit", ni_data_o);
                end else begin
                    expFlit = txExp.pop_front();
                    checkOutput("tx_flit", ni_data_o, expFlit);
                end
                pktPos = (pktPos + 1) % PKT_LEN;
            end
            creditBal = creditBal + (ni_credit_i ? 1 : 0) - (ni_valid_o ? 1 : 0);
            if (creditBal > BUF_DEPTH) creditBal = BUF_DEPTH;
            if (creditBal < 0) creditBal = 0;
            if (rx_read_i && rxModel.size() > 0) void'(rxModel.pop_front());
            if (ni_valid_i) begin
                rxFlitsIn++;
                if (rxModel.size() < RX_DEPTH) rxModel.push_back(ni_data_i);
                else ovfExp = 1'b1;
            end
        end
    end

    // PE payload source: retire the word the DUT took last edge, then offer the next one.
    always begin
        @(negedge clk);
        #1;
        if (readySeen && payQ.size() > 0) void'(payQ.pop_front());
        tx_payload_valid_i = payEn && (payQ.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        tx_payload_i = (payQ.size() > 0) ? payQ[0] : 16'($urandom);
        ni_credit_i = creditHold || (creditRand && $urandom_range(0, 3) == 0);
        #1;
        readySeen = tx_payload_ready_o;
        if (reset)
            checkOutput("tx_payload_ready", 32'(tx_payload_ready_o),
                        32'((pktPos != 0) && (creditBal > 0) && tx_payload_valid_i));
    end

    // RX checks just before the edge at which a pop would take effect.
    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            checkOutput("rx_valid", 32'(rx_valid_o), 32'(rxModel.size() > 0));
            checkOutput("ni_credit_o", 32'(ni_credit_o), 32'(rx_read_i && rxModel.size() > 0));
            checkOutput("rx_overflow", 32'(rx_overflow_o), 32'(ovfExp));
            if (rx_read_i && rxModel.size() > 0) begin
                checkOutput("rx_data", rx_data_o, rxModel[0]);
                creditsOut++;
            end
        end
    end

    task automatic waitIdle();
        int t = 0;
        while (tx_busy_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("wait_idle_timeout", 32'(tx_busy_o), 0);
    endtask

    task automatic applyStimulus(input logic [15:0] dest, input bit randPay, input logic [15:0] base);
        logic [15:0] w;
        waitIdle();
        txExp.push_back(dest);
        for (int i = 0; i < PKT_LEN - 1; i++) begin
            w = randPay ? 16'($urandom) : base + 16'(i);
            txExp.push_back(w);
            payQ.push_back(w);
        end
        pktsIssued++;
        tx_dest_i  = dest;
        tx_start_i = 1'b1;
        startCyc   = cyc + 1;
        @(negedge clk);
        tx_start_i = 1'b0;
        tx_dest_i  = 16'($urandom);
    endtask

    task automatic creditPulse();
        creditHold = 1'b1;
        @(negedge clk);
        creditHold = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int t = 0;
        while (txExp.size() > 0 && t < budget) begin
            if (!creditRand) creditHold = ~creditHold;
            @(negedge clk);
            t++;
        end
        creditHold = 1'b0;
        checkOutput("tx_drain_timeout", 32'(txExp.size()), 0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_ni_valid", 32'(ni_valid_o), 0);
        checkOutput("rst_ni_data", ni_data_o, 16'h0000);
        checkOutput("rst_busy", 32'(tx_busy_o), 0);
        checkOutput("rst_ready", 32'(tx_payload_ready_o), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid_o), 0);
        checkOutput("rst_rx_data", rx_data_o, 16'h0000);
        checkOutput("rst_overflow", 32'(rx_overflow_o), 0);
        checkOutput("rst_ni_credit", 32'(ni_credit_o), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; tx_start_i = 1'b0; tx_dest_i = 16'h0; ni_data_i = 16'h0;
        ni_valid_i = 1'b0; rx_read_i = 1'b0;
        #1;
        checkResetState();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single packet, back-to-back flits, header one edge after start.
        flitCyc.delete();
        applyStimulus(16'h0102, 1'b0, 16'h00A1);
        repeat (8) @(negedge clk);
        checkOutput("t1_flit_count", flitsSeen, 4);
        checkOutput("t1_header_latency", flitCyc[0], startCyc + 1);
        checkOutput("t1_back_to_back", flitCyc[3] - flitCyc[0], 3);

        // Credit starvation: 8 flits then stall; one credit releases exactly one flit.
        applyStimulus(16'h0304, 1'b1, 16'h0);
        applyStimulus(16'h0506, 1'b1, 16'h0);
        repeat (20) @(negedge clk);
        checkOutput("t2_stall_count", flitsSeen, 8);
        checkOutput("t2_busy_stalled", 32'(tx_busy_o), 1);
        creditPulse();
        repeat (10) @(negedge clk);
        checkOutput("t2_one_more", flitsSeen, 9);

        // Send and credit on the same edges from one credit: continuous flow, credit stays at 1.
        payEn = 1'b0;
        @(negedge clk);
        creditHold = 1'b1;
        @(negedge clk);
        payEn = 1'b1;
        flitCyc.delete();
        repeat (3) @(negedge clk);
        creditHold = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t3_flit_count", flitCyc.size(), 3);
        if (flitCyc.size() == 3) checkOutput("t3_continuous", flitCyc[2] - flitCyc[0], 2);
        applyStimulus(16'h0708, 1'b1, 16'h0);
        repeat (15) @(negedge clk);
        checkOutput("t3_credit_kept", flitsSeen, 13);

        // Surplus credits saturate at BUF_DEPTH.
        repeat (12) creditPulse();
        checkOutput("t4_drained", flitsSeen, 16);
        applyStimulus(16'h090A, 1'b1, 16'h0);
        applyStimulus(16'h0B0C, 1'b1, 16'h0);
        applyStimulus(16'h0D0E, 1'b1, 16'h0);
        repeat (20) @(negedge clk);
        checkOutput("t4_saturate", flitsSeen, 24);

        // RX: fill, overflow, drain in order, read on empty.
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            ni_valid_i = 1'b1;
            ni_data_i  = 16'($urandom);
            @(negedge clk);
        end
        ni_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("t6_full_valid", 32'(rx_valid_o), 1);
        checkOutput("t6_overflow", 32'(rx_overflow_o), 1);
        creditsOut = 0;
        rx_read_i = 1'b1;
        repeat (RX_DEPTH + 2) @(negedge clk);
        rx_read_i = 1'b0;
        @(negedge clk);
        checkOutput("t6_credits", creditsOut, RX_DEPTH);
        checkOutput("t6_empty", 32'(rx_valid_o), 0);
        repeat (200) begin
            ni_valid_i = ($urandom_range(0, 3) != 0);
            ni_data_i  = 16'($urandom);
            rx_read_i  = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        ni_valid_i = 1'b0;
        rx_read_i  = 1'b1;
        repeat (RX_DEPTH + 1) @(negedge clk);
        rx_read_i  = 1'b0;

        // Reset in BODY after two flits of a packet.
        creditPulse();
        creditPulse();
        repeat (3) @(negedge clk);
        checkOutput("t5_partial", flitsSeen, 26);
        checkOutput("t5_in_packet", 32'(tx_busy_o), 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkResetState();
        txExp.delete(); payQ.delete(); rxModel.delete(); flitCyc.delete();
        readySeen = 1'b0; creditBal = BUF_DEPTH; pktPos = 0; ovfExp = 1'b0;
        flitsSeen = 0; rxFlitsIn = 0; pktsIssued = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(16'($urandom), 1'b1, 16'h0);
        applyStimulus(16'($urandom), 1'b1, 16'h0);
        applyStimulus(16'($urandom), 1'b1, 16'h0);
        repeat (20) @(negedge clk);
        checkOutput("t5_fresh_credits", flitsSeen, 8);
        waitDrain(200);

        // Randomized packets with payload gaps and random credit returns.
        gaps = 1'b1;
        creditRand = 1'b1;
        repeat (6) applyStimulus(16'($urandom), 1'b1, 16'h0);
        waitDrain(600);
        creditRand = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rand_flit_total", flitsSeen, pktsIssued * PKT_LEN);

        for (int i = 0; i < 5; i++) begin
            ni_valid_i = 1'b1;
            ni_data_i  = 16'($urandom);
            @(negedge clk);
        end
        ni_valid_i = 1'b0;
        rx_read_i  = 1'b1;
        repeat (6) @(negedge clk);
        rx_read_i  = 1'b0;
        @(negedge clk);
`ifdef NI_STATS_EN
        checkOutput("stats_tx_pkts", tx_pkt_cnt_o, 16'(pktsIssued));
        checkOutput("stats_rx_flits", rx_flit_cnt_o, 16'd5);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
